// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter.
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_pkg;

   // Behaviour when a step would leave the 0..modulus range.
   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   // HALT is entered only after a one-shot terminal event.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// Latency: n/a (wiring only).
// Backpressure: none; controls are sampled every cycle.
interface updown_mod_counter_if
   import counter_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int STEP_WIDTH = 4
);
   logic                  load;
   logic [WIDTH-1:0]      load_value;
   logic                  enable;
   logic                  dir;
   logic [STEP_WIDTH-1:0] step;
   logic [WIDTH-1:0]      modulus;
   mode_e                 mode;
   logic [WIDTH-1:0]      count;
   logic                  tc;
   logic                  halted;

   // Controller side drives controls and observes status.
   modport master (
      output load, load_value, enable, dir, step, modulus, mode,
      input  count, tc, halted
   );

   // Counter side.
   modport slave (
      input  load, load_value, enable, dir, step, modulus, mode,
      output count, tc, halted
   );
endinterface

// File: rtl/counter_step_calc.sv
// Next-value and terminal detection for one step of the counter.
// Latency: purely combinational.
// Backpressure: none.
module counter_step_calc #(
   parameter int WIDTH      = 16,
   parameter int STEP_WIDTH = 4
) (
   input  logic [WIDTH-1:0]      count,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic                  dir,
   input  logic [WIDTH-1:0]      modulus,
   output logic [WIDTH-1:0]      next_val,
   output logic                  terminal
);
   logic [WIDTH-1:0] step_ext;
   logic [WIDTH:0]   sum;

   assign step_ext = WIDTH'(step);

   // The extra sum bit keeps overflow visible so count+step never aliases back into range.
   always_comb begin
      sum      = {1'b0, count} + {1'b0, step_ext};
      next_val = dir ? (count - step_ext) : sum[WIDTH-1:0];
      terminal = 1'b0;
      if (step_ext != '0) begin
         if (count > modulus) begin
            // Modulus was lowered under the current count.
            terminal = 1'b1;
         end else if (dir) begin
            terminal = (count < step_ext);
         end else begin
            terminal = (sum > {1'b0, modulus});
         end
      end
   end
endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap/saturate/one-shot terminal handling and tc pulse.
// Latency: 1 cycle from load/enable to count, tc and halted (all registered).
// Backpressure: none; HALT ignores enable until load or reset.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int STEP_WIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   updown_mod_counter_if.slave bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             halted_q, halted_d;
   logic [WIDTH-1:0] next_val;
   logic             terminal;
   logic [WIDTH-1:0] load_clamped;

   counter_step_calc #(
      .WIDTH      (WIDTH),
      .STEP_WIDTH (STEP_WIDTH)
   ) u_step_calc (
      .count    (count_q),
      .step     (bus.step),
      .dir      (bus.dir),
      .modulus  (bus.modulus),
      .next_val (next_val),
      .terminal (terminal)
   );

   assign load_clamped = (bus.load_value > bus.modulus) ? bus.modulus : bus.load_value;

   // Next state: load beats enable; terminal handling depends on mode and direction.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (bus.load) begin
         count_d = load_clamped;
         state_d = ST_RUN;
      end else if (bus.enable && (state_q == ST_RUN)) begin
         if (terminal) begin
            tc_d = 1'b1;
            case (bus.mode)
               MODE_SAT: begin
                  count_d = bus.dir ? '0 : bus.modulus;
               end
               MODE_ONESHOT: begin
                  count_d = bus.dir ? '0 : bus.modulus;
                  state_d = ST_HALT;
               end
               default: begin
                  // Wrap, and the reserved encoding which behaves as wrap.
                  count_d = bus.dir ? bus.modulus : '0;
               end
            endcase
         end else begin
            count_d = next_val;
         end
      end
      halted_d = (state_d == ST_HALT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         count_q  <= '0;
         tc_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         tc_q     <= tc_d;
         halted_q <= halted_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.tc     = tc_q;
   assign bus.halted = halted_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: vector table plus hand-written HALT/reset sequences.
// Latency: expectations are checked 1 ns after the edge that registers each vector.
// Backpressure: n/a.
module tb_updown_mod_counter;
   import counter_pkg::*;

   localparam int W  = 8;
   localparam int SW = 4;

   typedef struct {
      logic          rst;
      logic          ld;
      logic [W-1:0]  lv;
      logic          en;
      logic          dir;
      logic [SW-1:0] st;
      logic [W-1:0]  md;
      logic [1:0]    mo;
      logic [W-1:0]  ec;
      logic          et;
      logic          eh;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vq[$];

   updown_mod_counter_if #(.WIDTH(W), .STEP_WIDTH(SW)) bus ();

   updown_mod_counter #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic ld, logic [W-1:0] lv, logic en, logic d,
                               logic [SW-1:0] st, logic [W-1:0] md, logic [1:0] mo,
                               logic [W-1:0] ec, logic et, logic eh);
      vec_t v;
      v.rst = r; v.ld = ld; v.lv = lv; v.en = en; v.dir = d; v.st = st;
      v.md = md; v.mo = mo; v.ec = ec; v.et = et; v.eh = eh;
      return v;
   endfunction

   task automatic check(string name, logic [W-1:0] ec, logic et, logic eh);
      checks++;
      if (bus.count !== ec) begin
         failures++;
         $display("FAIL %s count: got %0d expected %0d", name, bus.count, ec);
      end
      checks++;
      if (bus.tc !== et) begin
         failures++;
         $display("FAIL %s tc: got %0b expected %0b", name, bus.tc, et);
      end
      checks++;
      if (bus.halted !== eh) begin
         failures++;
         $display("FAIL %s halted: got %0b expected %0b", name, bus.halted, eh);
      end
   endtask

   task automatic apply(vec_t v, string name);
      reset          = v.rst;
      bus.load       = v.ld;
      bus.load_value = v.lv;
      bus.enable     = v.en;
      bus.dir        = v.dir;
      bus.step       = v.st;
      bus.modulus    = v.md;
      bus.mode       = mode_e'(v.mo);
      @(posedge clk);
      #1;
      check(name, v.ec, v.et, v.eh);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0; bus.dir = 1'b0;
      bus.step = '0;   bus.modulus = '0;    bus.mode = MODE_WRAP;

      // reset, then up-count 0..9 with wrap on modulus 9
      vq.push_back(mk(1, 0, 0, 1, 0, 1, 9, 0, 0, 0, 0));
      for (int i = 1; i <= 9; i++) vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 0, W'(i), 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
      // saturate down with step 3 on modulus 10, then reverse
      vq.push_back(mk(0, 1, 5, 0, 1, 3, 10, 1, 5, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 1, 3, 10, 1, 2, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 1, 3, 10, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 1, 1, 3, 10, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 3, 10, 1, 3, 0, 0));
      // saturate up, repeated tc, load beats enable
      vq.push_back(mk(0, 1, 9, 0, 0, 1, 9, 1, 9, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 1, 9, 1, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 1, 9, 1, 0));
      vq.push_back(mk(0, 1, 3, 1, 0, 1, 9, 1, 3, 0, 0));
      // load clamp, then modulus lowered under the count
      vq.push_back(mk(0, 1, 200, 0, 0, 1, 50, 0, 50, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 1, 20, 0, 0, 1, 0));
      // wrap going down lands on modulus; reserved mode wraps up
      vq.push_back(mk(0, 1, 1, 0, 1, 2, 9, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 1, 2, 9, 0, 9, 1, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 3, 0, 1, 0));
      // modulus 0: every nonzero enabled step is terminal
      vq.push_back(mk(0, 1, 7, 0, 0, 5, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 5, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0, 0, 1, 0));
      // one-shot up on modulus 4 with step 2
      vq.push_back(mk(0, 1, 0, 0, 0, 2, 4, 2, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 2, 4, 2, 2, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 2, 4, 2, 4, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 2, 4, 2, 4, 1, 1));

      foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

      // HALT ignores enable for several cycles, in both directions
      for (int i = 0; i < 5; i++)
         apply(mk(0, 0, 0, 1, i[0], 2, 4, 2, 4, 0, 1), $sformatf("halt_hold%0d", i));
      apply(mk(0, 1, 1, 1, 0, 2, 4, 2, 1, 0, 0), "halt_load_exit");

      // re-enter HALT via one-shot down, then reset wins over load and enable
      apply(mk(0, 0, 0, 1, 1, 3, 4, 2, 0, 1, 1), "oneshot_down");
      apply(mk(1, 1, 3, 1, 0, 1, 4, 2, 0, 0, 0), "reset_in_halt");
      apply(mk(0, 0, 0, 1, 0, 1, 4, 2, 1, 0, 0), "run_after_reset");

      // step 0 at count == modulus holds without tc
      apply(mk(0, 1, 4, 0, 0, 0, 4, 0, 4, 0, 0), "load_at_mod");
      apply(mk(0, 0, 0, 1, 0, 0, 4, 0, 4, 0, 0), "step0_hold");
      apply(mk(0, 0, 0, 1, 1, 0, 4, 0, 4, 0, 0), "step0_hold_down");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter, successor to the team's basic loadable up-counter. Adds programmable modulus, per-cycle step size, direction control, three terminal behaviours (wrap, saturate, one-shot) and a registered terminal-count pulse. It sits in timer and sequencer datapaths where the plain free-running counter lacks range control and end-of-count signalling.

## Interface
Parameters:
- WIDTH, 16, width of count, modulus and load value
- STEP_WIDTH, 4, width of step input; must be ≤ WIDTH

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  load count from load_value
- load_value  in  WIDTH  value to load
- enable  in  1  advance count by step this cycle
- dir  in  1  0 = count up, 1 = count down
- step  in  STEP_WIDTH  increment/decrement amount
- modulus  in  WIDTH  maximum count value (inclusive); range is 0..modulus
- mode  in  2  terminal behaviour, encoded per counter_pkg::mode_e
- count  out  WIDTH  current count
- tc  out  1  one-cycle pulse, registered, on terminal event
- halted  out  1  high while in HALT (one-shot finished)

## Operation
- States: RUN, HALT. Reset → RUN.
- Priority per cycle: reset > load > enable > hold.
- reset: count=0, tc=0, halted=0, state=RUN.
- load: count = min(load_value, modulus); state=RUN; tc=0. Load is honoured in HALT.
- enable in RUN, step ≠ 0:
  - Up: sum = count + step computed in WIDTH+1 bits; terminal event if sum > modulus, else count=sum.
  - Down: terminal event if count < step, else count = count − step.
  - Terminal event also fires on any enabled step when count > modulus (modulus lowered at runtime).
- On terminal event, by mode:
  - MODE_WRAP (00): up → count=0; down → count=modulus.
  - MODE_SAT (01): up → count=modulus; down → count=0; stays RUN; reversing dir resumes counting.
  - MODE_ONESHOT (10): up → count=modulus; down → count=0; state=HALT.
  - 11 reserved: behaves as MODE_WRAP.
- tc=1 for exactly the cycle following each terminal event; in MODE_SAT, each further enabled step pushing past the limit fires tc again.
- HALT: enable ignored, count held, halted=1; only load or reset exits.
- step=0 with enable: count held, no terminal event, even if count==modulus.
- modulus=0: count stays 0; every enabled nonzero step is a terminal event.
- mode and dir sampled per cycle; changing them mid-count affects only the next step.

## Timing
- All outputs registered; count, tc and halted update one clock after the qualifying input cycle.
- Latency load → count: 1 cycle. enable → count/tc: 1 cycle.
- tc and the terminal count value appear in the same cycle.
- No combinational input→output path.
- Reset mid-count or in HALT takes effect on the next edge regardless of other inputs.

## Structure
- counter_pkg: mode_e enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD), state_e enum (ST_RUN, ST_HALT).
- One combinational sub-module, counter_step_calc: takes count, step, dir, modulus; returns next value and terminal flag. Top-level holds state register, mode handling, load clamp and output registers.

## Test plan
- WIDTH=8, modulus=9, step=1, up, MODE_WRAP, enable 10 cycles from 0 → count 1..9 then 0; tc high only in the cycle count returns to 0.
- modulus=10, step=3, down, MODE_SAT, load 5 → count 2, then 0 with tc; next enable → count 0, tc again; dir=up → 3.
- MODE_ONESHOT, modulus=4, step=2, up from 0 → 2, 4, then a terminal event → count 4, tc, halted=1; enable held 5 cycles → no change; load 1 → count 1, halted=0.
- load_value=200, modulus=50 → count 50; lower modulus to 20 with enable, up, MODE_WRAP → terminal event, count 0, tc.
- reset asserted while in HALT with load and enable also high → count 0, halted 0, tc 0 next cycle; step=0 with enable at count=modulus → no tc.
